// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed-image protocol FSM
// that writes big-endian 32-bit words into instruction memory and holds the CPU meanwhile.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 16,
  parameter int MAX_WORDS    = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       word_cnt
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [16:0]      MAX_N     = 17'(MAX_WORDS);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA, S_CKSUM, S_ERR} state_t;

  rx_state_t        r_rx_state;
  logic             r_rx_meta;
  logic             r_rx_sync;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             r_byte_valid;
  logic             r_fe;

  state_t           r_state;
  logic [7:0]       r_cnt_hi;
  logic [15:0]      r_n;
  logic [23:0]      r_shift;
  logic [1:0]       r_byte_idx;
  logic [7:0]       r_xor;
  logic             r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]      r_mem_wr_data;
  logic             r_cpu_hold;
  logic             r_load_done;
  logic             r_load_err;
  logic [15:0]      r_word_cnt;

  logic             w_rx_fall;
  logic [7:0]       w_rx_byte;
  logic [15:0]      w_n_new;
  logic [31:0]      w_word;
  logic [15:0]      w_cnt_next;

  assign w_rx_fall  = r_rx_prev & ~r_rx_sync;
  assign w_rx_byte  = r_rx_shift;
  assign w_n_new    = {r_cnt_hi, w_rx_byte};
  assign w_word     = {r_shift, w_rx_byte};
  assign w_cnt_next = r_word_cnt + 16'd1;

  // Input synchroniser and edge-detect history; preset high to match an idle line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // UART bit timing and deserialiser; byte_valid / fe are single-cycle pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= RX_IDLE;
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_rx_shift   <= 8'd0;
      r_byte_valid <= 1'b0;
      r_fe         <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_fe         <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= 3'd0;
          if (w_rx_fall) r_rx_state <= RX_START;
          else           r_rx_state <= RX_IDLE;
        end
        RX_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt  <= r_clk_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt  <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            else                   r_bit_idx  <= r_bit_idx + 3'd1;
          end else begin
            r_clk_cnt  <= r_clk_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt  <= '0;
            if (r_rx_sync) r_byte_valid <= 1'b1;
            else           r_fe         <= 1'b1;
            r_rx_state <= RX_IDLE;
          end else begin
            r_clk_cnt  <= r_clk_cnt + CNT_ONE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Frame protocol: header, count, data words, checksum; drives all memory and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt_hi      <= 8'd0;
      r_n           <= 16'd0;
      r_shift       <= 24'd0;
      r_byte_idx    <= 2'd0;
      r_xor         <= 8'd0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= 32'd0;
      r_cpu_hold    <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_word_cnt    <= 16'd0;
    end else begin
      r_mem_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_byte_valid && (w_rx_byte == SYNC_BYTE)) begin
            r_state    <= S_CNT_HI;
            r_cpu_hold <= 1'b1;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        S_CNT_HI: begin
          if (r_fe) begin
            r_state <= S_ERR;
          end else if (r_byte_valid) begin
            r_cnt_hi <= w_rx_byte;
            r_state  <= S_CNT_LO;
          end else begin
            r_state  <= S_CNT_HI;
          end
        end
        S_CNT_LO: begin
          if (r_fe) begin
            r_state <= S_ERR;
          end else if (r_byte_valid) begin
            r_n         <= w_n_new;
            r_word_cnt  <= 16'd0;
            r_xor       <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            if (w_n_new == 16'd0)             r_state <= S_CKSUM;
            else if ({1'b0, w_n_new} > MAX_N) r_state <= S_ERR;
            else                              r_state <= S_DATA;
          end else begin
            r_state <= S_CNT_LO;
          end
        end
        S_DATA: begin
          if (r_fe) begin
            r_state <= S_ERR;
          end else if (r_byte_valid) begin
            r_shift    <= {r_shift[15:0], w_rx_byte};
            r_xor      <= r_xor ^ w_rx_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_data <= w_word;
              r_mem_addr    <= ADDR_W'(r_word_cnt) << 2;
              r_word_cnt    <= w_cnt_next;
              if (w_cnt_next == r_n) r_state <= S_CKSUM;
              else                   r_state <= S_DATA;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_state <= S_DATA;
          end
        end
        S_CKSUM: begin
          if (r_fe) begin
            r_state <= S_ERR;
          end else if (r_byte_valid) begin
            if (w_rx_byte == r_xor) r_load_done <= 1'b1;
            else                    r_load_err  <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_CKSUM;
          end
        end
        S_ERR: begin
          r_load_err  <= 1'b1;
          r_load_done <= 1'b0;
          r_cpu_hold  <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_wr_en   = r_mem_wr_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign cpu_hold    = r_cpu_hold;
  assign load_done   = r_load_done;
  assign load_err    = r_load_err;
  assign word_cnt    = r_word_cnt;

endmodule
